bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//  Sequential BCD-to-binary converter (reverse double dabble); inverse of the FX33 binary-to-BCD path.
//  Takes three packed decimal digits (hundreds/tens/ones) and produces an 8-bit binary value.
//  Used where the CPU or debug/keypad front-end must turn decimal digits back into a register value.
//  Iterative, one shift per clock, with a start/done handshake; lives beside the CPU datapath.
// PARAMETERS
//  BIN_W   8   result width; also the number of shift cycles
//  DIGITS  3   number of 4-bit BCD input digits; the BCD register is 4*DIGITS bits wide
// PORTS
//  clk       in   1   system clock
//  reset_n   in   1   asynchronous, active-low reset
//  start     in   1   request conversion; sampled only in IDLE
//  hundreds  in   4   BCD digit 2 (most significant)
//  tens      in   4   BCD digit 1
//  ones      in   4   BCD digit 0
//  busy      out  1   high while a conversion is in progress (LOAD through DONE)
//  done      out  1   one-cycle pulse: the result outputs are valid and updated
//  num       out  8   binary result; holds its value until the next done
//  ovf       out  1   value >= 2**BIN_W (e.g. 256..999); updated with done
//  dig_err   out  1   an input digit was > 9 when sampled; updated with done
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE; busy=0, done=0, num=0, ovf=0, dig_err=0; shift reg and count cleared.
//  Clock and reset are the only timing inputs. Reset takes effect immediately.
//  Reset mid-conversion aborts the conversion. No done is produced for the aborted request.
//  FSM states (in the package): IDLE, SHIFT, DONE.
//   IDLE : if start=1 at edge T, load sr[4*DIGITS+BIN_W-1:0] = {hundreds,tens,ones,BIN_W'b0}.
//          At the same edge: latch dig_err_q = (any digit > 9), cnt=0, go to SHIFT.
//          busy=1 from T+1.
//   SHIFT: each cycle sr = sr >> 1; then every BCD nibble of the shifted value that is >= 8 is reduced by 3.
//          All nibbles are corrected in parallel, in the same cycle. cnt++.
//          After BIN_W shifts (cnt==BIN_W-1), go to DONE.
//   DONE : done=1 for exactly one cycle. Registered outputs are updated at entry to DONE.
//          ovf = (BCD part of sr != 0).
//          dig_err = dig_err_q.
//          num = dig_err_q ? 0 : sr[BIN_W-1:0]. ovf still reports the truncation, and num = low BIN_W bits.
//          Next state is IDLE.
//  Latency: start at edge T gives done=1 during cycle T+BIN_W+1 (T+9 at defaults).
//  Throughput: at most one conversion per BIN_W+2 cycles.
//  Handshake: start while busy=1 is ignored (not queued).
//  Handshake: start held high in IDLE re-triggers on the cycle after DONE.
//  Inputs are sampled only at the start edge; later digit changes do not affect the result.
//  Arithmetic: the correction uses 4-bit unsigned subtraction.
//   A valid-digit pipeline never sees a nibble of 8..15 below 8 after the subtract.
//   Invalid digits still run through the correction with 4-bit wrap; only the flag and num=0 are defined.
//  ovf and dig_err may both be 1.
// STRUCTURE
//  Package bcd_pkg holds:
//   - typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;
//   - BCD_DIGIT_MAX = 4'd9
//   - BCD_ADJ = 4'd3
//   - BCD_ADJ_THRESH_R = 4'd8
//  Sub-module bcd_nibble_unadj (combinational): out = (in >= 8) ? in - 3 : in.
//   Instantiated DIGITS times via generate.
//  Top block holds the FSM, the counter (width $clog2(BIN_W)) and the shift register.
//  All outputs are registered; no combinational path from the inputs to any output.
// TESTING
//  1. 2,5,5 with start -> done at T+9; num=0xFF, ovf=0, dig_err=0; busy high T+1..T+9.
//  2. 0,0,0 -> num=0x00, ovf=0. 1,2,3 -> num=0x7B. 0,0,9 -> num=0x09.
//  3. 2,5,6 -> ovf=1, num=0x00. 9,9,9 -> ovf=1, num=0xE7 (999 mod 256).
//  4. 0,0xA,1 -> dig_err=1, num=0x00; the next valid request 0,4,2 -> num=0x2A, dig_err=0.
//  5. start 1,0,0, then pulse start with 2,0,0 at T+3 -> exactly one done; num=0x64.
//  6. reset_n low at T+4 of a conversion -> all outputs 0 immediately, no done.
//     A following 0,1,6 -> num=0x10.
//  Plus: an exhaustive self-check of 0..999 against a reference model (value%256, value>255).

Source files
------------

// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types and constants for the BCD-to-binary converter.
//   bcd_state_t      : converter FSM states
//   BCD_DIGIT_MAX    : largest legal BCD digit
//   BCD_ADJ          : amount removed from a corrected nibble
//   BCD_ADJ_THRESH_R : nibble value at/above which the correction applies
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } bcd_state_t;

  localparam logic [3:0] BCD_DIGIT_MAX    = 4'd9;
  localparam logic [3:0] BCD_ADJ          = 4'd3;
  localparam logic [3:0] BCD_ADJ_THRESH_R = 4'd8;

endpackage

// File: rtl/bcd_to_bin_if.sv
// bcd_to_bin_if: request/response bundle of the BCD-to-binary converter.
//   start, hundreds, tens, ones : request side (master drives)
//   busy, done, num, ovf, dig_err : response side (slave drives)
interface bcd_to_bin_if #(
  parameter int BIN_W = 8
);
  logic             start;
  logic [3:0]       hundreds;
  logic [3:0]       tens;
  logic [3:0]       ones;
  logic             busy;
  logic             done;
  logic [BIN_W-1:0] num;
  logic             ovf;
  logic             dig_err;

  modport master (
    output start, hundreds, tens, ones,
    input  busy, done, num, ovf, dig_err
  );

  modport slave (
    input  start, hundreds, tens, ones,
    output busy, done, num, ovf, dig_err
  );
endinterface

// File: rtl/bcd_nibble_unadj.sv
// bcd_nibble_unadj: per-digit correction step of reverse double dabble.
//   din  : 4-bit nibble after the right shift
//   dout : din - 3 when din >= 8, else din (4-bit wrap for illegal values)
module bcd_nibble_unadj
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH_R) ? (din - BCD_ADJ) : din;

endmodule

// File: rtl/bcd_to_bin.sv
// bcd_to_bin: iterative BCD-to-binary converter (reverse double dabble),
// one right shift per clock with a start/done handshake.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : slave side of bcd_to_bin_if
//              start/hundreds/tens/ones in; busy/done/num/ovf/dig_err out
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; digits are captured on the start edge
// SHIFT | BIN_W shift-and-correct iterations
// DONE  | one-cycle done pulse; results were loaded on entry
module bcd_to_bin
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  bcd_to_bin_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int SR_W  = BCD_W + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  bcd_state_t       state;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic             dig_err_q;

  logic [BCD_W-1:0] digs;
  logic             dig_bad;
  logic [SR_W-1:0]  sr_sh;
  logic [BCD_W-1:0] nib_adj;
  logic [SR_W-1:0]  sr_next;

  assign digs = BCD_W'({bus.hundreds, bus.tens, bus.ones});

  always_comb begin
    dig_bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digs[4*i +: 4] > BCD_DIGIT_MAX) dig_bad = 1'b1;
    end
  end

  // Shift first, then correct every BCD nibble of the shifted value in parallel.
  assign sr_sh = sr >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_unadj
    bcd_nibble_unadj u_unadj (
      .din  (sr_sh[BIN_W + 4*g +: 4]),
      .dout (nib_adj[4*g +: 4])
    );
  end

  assign sr_next = {nib_adj, sr_sh[BIN_W-1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      sr          <= '0;
      cnt         <= '0;
      dig_err_q   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.num     <= '0;
      bus.ovf     <= 1'b0;
      bus.dig_err <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            sr        <= {digs, {BIN_W{1'b0}}};
            dig_err_q <= dig_bad;
            cnt       <= '0;
            bus.busy  <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            // Results are taken from the final shifted value as DONE is entered.
            state       <= DONE;
            bus.done    <= 1'b1;
            bus.ovf     <= |sr_next[SR_W-1:BIN_W];
            bus.dig_err <= dig_err_q;
            bus.num     <= dig_err_q ? '0 : sr_next[BIN_W-1:0];
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// tb_bcd_to_bin: scoreboard bench for bcd_to_bin. Stimulus pushes the expected
// result of each accepted request; a monitor pops and compares on every done.
module tb_bcd_to_bin;

  typedef struct {
    logic [7:0] num;
    logic       ovf;
    logic       chk_ovf;
    logic       dig_err;
    string      name;
  } exp_t;

  logic clk;
  logic reset_n;
  int   tests;
  int   failed;
  exp_t sb[$];

  bcd_to_bin_if #(.BIN_W(8)) bus ();

  bcd_to_bin #(.BIN_W(8), .DIGITS(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare every done pulse against the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_done: got num=%0h with no request outstanding", bus.num);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check({e.name, ".num"}, 32'(bus.num), 32'(e.num));
        check({e.name, ".dig_err"}, 32'(bus.dig_err), 32'(e.dig_err));
        if (e.chk_ovf) check({e.name, ".ovf"}, 32'(bus.ovf), 32'(e.ovf));
      end
    end
  end

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (bus.done !== 1'b1 && k < 30) begin
      @(negedge clk);
      k++;
    end
    if (bus.done !== 1'b1) begin
      tests++;
      failed++;
      $display("FAIL %s.timeout: got no done, expected done within 30 cycles", name);
    end
    @(negedge clk);
  endtask

  task automatic convert(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
                         input logic [7:0] num, input logic ovf, input logic chk_ovf,
                         input logic dig_err, input string name);
    exp_t e;
    e.num = num; e.ovf = ovf; e.chk_ovf = chk_ovf; e.dig_err = dig_err; e.name = name;
    sb.push_back(e);
    bus.hundreds = h; bus.tens = t; bus.ones = o;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hundreds = 4'hF; bus.tens = 4'hF; bus.ones = 4'hF;
    wait_done(name);
  endtask

  initial begin
    int first_done;
    tests = 0;
    failed = 0;
    bus.start = 1'b0;
    bus.hundreds = 4'd0; bus.tens = 4'd0; bus.ones = 4'd0;
    reset_n = 1'b0;
    #23;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.num", 32'(bus.num), 32'd0);
    check("reset.ovf", 32'(bus.ovf), 32'd0);
    check("reset.dig_err", 32'(bus.dig_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: 255 with latency/busy profile; negedge k follows edge T+k-1.
    begin
      exp_t e;
      e.num = 8'hFF; e.ovf = 1'b0; e.chk_ovf = 1'b1; e.dig_err = 1'b0; e.name = "d255";
      sb.push_back(e);
    end
    bus.hundreds = 4'd2; bus.tens = 4'd5; bus.ones = 4'd5;
    bus.start = 1'b1;
    first_done = 0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("d255.busy_c%0d", k), 32'(bus.busy), (k <= 9) ? 32'd1 : 32'd0);
      if (bus.done === 1'b1 && first_done == 0) first_done = k;
    end
    check("d255.latency", 32'(first_done), 32'd9);

    // 2..4: directed values
    convert(4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b1, 1'b0, "d000");
    convert(4'd1, 4'd2, 4'd3, 8'h7B, 1'b0, 1'b1, 1'b0, "d123");
    convert(4'd0, 4'd0, 4'd9, 8'h09, 1'b0, 1'b1, 1'b0, "d009");
    convert(4'd2, 4'd5, 4'd6, 8'h00, 1'b1, 1'b1, 1'b0, "d256");
    convert(4'd9, 4'd9, 4'd9, 8'hE7, 1'b1, 1'b1, 1'b0, "d999");
    convert(4'd0, 4'hA, 4'd1, 8'h00, 1'b0, 1'b0, 1'b1, "bad0A1");
    convert(4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b1, 1'b0, "d042");

    // 5: second start during busy is dropped
    begin
      exp_t e;
      e.num = 8'h64; e.ovf = 1'b0; e.chk_ovf = 1'b1; e.dig_err = 1'b0; e.name = "d100";
      sb.push_back(e);
    end
    bus.hundreds = 4'd1; bus.tens = 4'd0; bus.ones = 4'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.hundreds = 4'd2;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.hundreds = 4'd0;
    wait_done("d100");
    repeat (12) @(negedge clk);
    check("d100.sb_empty", 32'(sb.size()), 32'd0);

    // 6: reset mid-conversion
    bus.hundreds = 4'd9; bus.tens = 4'd9; bus.ones = 4'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort.busy", 32'(bus.busy), 32'd0);
    check("abort.done", 32'(bus.done), 32'd0);
    check("abort.num", 32'(bus.num), 32'd0);
    check("abort.ovf", 32'(bus.ovf), 32'd0);
    check("abort.dig_err", 32'(bus.dig_err), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    convert(4'd0, 4'd1, 4'd6, 8'h10, 1'b0, 1'b1, 1'b0, "d016");

    // Exhaustive 0..999 against value%256 / value>255
    for (int v = 0; v < 1000; v++) begin
      convert(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10),
              8'(v % 256), (v > 255), 1'b1, 1'b0, $sformatf("v%0d", v));
    end

    repeat (3) @(negedge clk);
    check("final.sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
